// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: word-organised data RAM plus the MEM/WB pipeline register.
// Define MEMSTAGE_SUBWORD_EN for byte/halfword access; otherwise every access is a full word.
module mem_access_stage #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        iStall,
   input  logic        iFlush,
   input  logic        iSig_MemRead,
   input  logic        iSig_MemWrite,
   input  logic        iSig_MemtoReg,
   input  logic        iSig_regfile_write,
   input  logic [1:0]  iMemSize,
   input  logic        iMemUnsigned,
   input  logic [31:0] ialu_result,
   input  logic [31:0] iwrite_data,
   input  logic [4:0]  iwrite_reg,
   output logic [31:0] oread_from_ram,
   output logic [31:0] oalu_result,
   output logic [4:0]  owrite_reg,
   output logic        oSig_MemtoReg,
   output logic        oSig_RegfileWrite,
   output logic        oMisaligned
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]           ram [DEPTH];
   logic [DEPTH_LOG2-1:0] word_idx;
   logic [1:0]            byte_off;
   logic [31:0]           ram_word;
   logic                  access;
   logic                  misaligned;
   logic [31:0]           load_data;
   logic [31:0]           store_word;
   logic                  ram_we;

   // Address bits above the RAM depth are dropped, so addresses wrap.
   assign word_idx = ialu_result[DEPTH_LOG2+1:2];
   assign byte_off = ialu_result[1:0];
   assign ram_word = ram[word_idx];
   assign access   = iSig_MemRead | iSig_MemWrite;

`ifdef MEMSTAGE_SUBWORD_EN
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        unused_addr;

   assign unused_addr = ^ialu_result[31:DEPTH_LOG2+2];

   // Big-endian lanes: byte offset 0 is the most significant byte.
   always_comb begin
      byte_lane = 8'h00;
      case (byte_off)
         2'd0:    byte_lane = ram_word[31:24];
         2'd1:    byte_lane = ram_word[23:16];
         2'd2:    byte_lane = ram_word[15:8];
         default: byte_lane = ram_word[7:0];
      endcase
      half_lane = byte_off[1] ? ram_word[15:0] : ram_word[31:16];
   end

   always_comb begin
      misaligned = 1'b0;
      load_data  = ram_word;
      store_word = iwrite_data;
      case (iMemSize)
         2'b00: begin
            misaligned = 1'b0;
            load_data  = iMemUnsigned ? {24'h000000, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
            store_word = ram_word;
            case (byte_off)
               2'd0:    store_word[31:24] = iwrite_data[7:0];
               2'd1:    store_word[23:16] = iwrite_data[7:0];
               2'd2:    store_word[15:8]  = iwrite_data[7:0];
               default: store_word[7:0]   = iwrite_data[7:0];
            endcase
         end
         2'b01: begin
            misaligned = byte_off[0];
            load_data  = iMemUnsigned ? {16'h0000, half_lane}
                                      : {{16{half_lane[15]}}, half_lane};
            store_word = byte_off[1] ? {ram_word[31:16], iwrite_data[15:0]}
                                     : {iwrite_data[15:0], ram_word[15:0]};
         end
         default: begin
            misaligned = |byte_off;
            load_data  = ram_word;
            store_word = iwrite_data;
         end
      endcase
      misaligned = misaligned & access;
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^{iMemSize, iMemUnsigned, ialu_result[31:DEPTH_LOG2+2]};
   assign misaligned = access & (|byte_off);
   assign load_data  = ram_word;
   assign store_word = iwrite_data;
`endif

   // A store is dropped while stalled, flushed, misaligned or held in reset.
   assign ram_we = rstn & iSig_MemWrite & ~iStall & ~iFlush & ~misaligned;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[word_idx] <= store_word;
      end
   end

   // MEM/WB register: flush beats stall beats normal capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         oread_from_ram    <= 32'h0;
         oalu_result       <= 32'h0;
         owrite_reg        <= 5'd0;
         oSig_MemtoReg     <= 1'b0;
         oSig_RegfileWrite <= 1'b0;
         oMisaligned       <= 1'b0;
      end else if (iFlush) begin
         oread_from_ram    <= 32'h0;
         oalu_result       <= 32'h0;
         owrite_reg        <= 5'd0;
         oSig_MemtoReg     <= 1'b0;
         oSig_RegfileWrite <= 1'b0;
         oMisaligned       <= 1'b0;
      end else if (!iStall) begin
         oread_from_ram    <= iSig_MemRead ? load_data : 32'h0;
         oalu_result       <= ialu_result;
         owrite_reg        <= iwrite_reg;
         oSig_MemtoReg     <= iSig_MemtoReg;
         oSig_RegfileWrite <= iSig_regfile_write & ~misaligned;
         oMisaligned       <= misaligned;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; sub-word steps run only when MEMSTAGE_SUBWORD_EN is defined.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rstn;
   logic        iStall, iFlush, iSig_MemRead, iSig_MemWrite, iSig_MemtoReg, iSig_regfile_write;
   logic [1:0]  iMemSize;
   logic        iMemUnsigned;
   logic [31:0] ialu_result, iwrite_data;
   logic [4:0]  iwrite_reg;
   logic [31:0] oread_from_ram, oalu_result;
   logic [4:0]  owrite_reg;
   logic        oSig_MemtoReg, oSig_RegfileWrite, oMisaligned;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_word;

   mem_access_stage #(.DEPTH_LOG2(10)) dut (
      .clk(clk), .rstn(rstn), .iStall(iStall), .iFlush(iFlush),
      .iSig_MemRead(iSig_MemRead), .iSig_MemWrite(iSig_MemWrite),
      .iSig_MemtoReg(iSig_MemtoReg), .iSig_regfile_write(iSig_regfile_write),
      .iMemSize(iMemSize), .iMemUnsigned(iMemUnsigned),
      .ialu_result(ialu_result), .iwrite_data(iwrite_data), .iwrite_reg(iwrite_reg),
      .oread_from_ram(oread_from_ram), .oalu_result(oalu_result), .owrite_reg(owrite_reg),
      .oSig_MemtoReg(oSig_MemtoReg), .oSig_RegfileWrite(oSig_RegfileWrite),
      .oMisaligned(oMisaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] rd, input logic [31:0] alu,
                          input logic [4:0] wreg, input logic mtr, input logic rfw,
                          input logic mis);
      chk({tag, ".rd"},   oread_from_ram, rd);
      chk({tag, ".alu"},  oalu_result, alu);
      chk({tag, ".wreg"}, {27'd0, owrite_reg}, {27'd0, wreg});
      chk({tag, ".mtr"},  {31'd0, oSig_MemtoReg}, {31'd0, mtr});
      chk({tag, ".rfw"},  {31'd0, oSig_RegfileWrite}, {31'd0, rfw});
      chk({tag, ".mis"},  {31'd0, oMisaligned}, {31'd0, mis});
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wreg, input logic mtr, input logic rfw,
                        input logic stall, input logic flush);
      iSig_MemRead       = rd;
      iSig_MemWrite      = wr;
      iMemSize           = sz;
      iMemUnsigned       = uns;
      ialu_result        = addr;
      iwrite_data        = wdata;
      iwrite_reg         = wreg;
      iSig_MemtoReg      = mtr;
      iSig_regfile_write = rfw;
      iStall             = stall;
      iFlush             = flush;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] sz);
      drive(1'b0, 1'b1, sz, 1'b0, addr, wdata, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
   endtask

   task automatic issue_load(input logic [31:0] addr, input logic [4:0] wreg,
                             input logic [1:0] sz, input logic uns, input logic [31:0] exp);
      drive(1'b1, 1'b0, sz, uns, addr, 32'h0, wreg, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(exp);
   endtask

   task automatic check_load(input string tag, input logic [31:0] addr, input logic [4:0] wreg);
      logic [31:0] exp;
      exp = exp_q.pop_front();
      chk_all(tag, exp, addr, wreg, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic load(input string tag, input logic [31:0] addr, input logic [4:0] wreg,
                       input logic [1:0] sz, input logic uns, input logic [31:0] exp);
      issue_load(addr, wreg, sz, uns, exp);
      step();
      check_load(tag, addr, wreg);
   endtask

   initial begin
      // Reset with idle inputs
      rstn = 1'b0;
      drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      rstn = 1'b1;

      // Word store then load of the same word on the next cycle
      store(32'h10, 32'hDEADBEEF, 2'b10);
      chk_all("sw_10", 32'h0, 32'h10, 5'd0, 1'b0, 1'b0, 1'b0);
      load("lw_10", 32'h10, 5'd8, 2'b10, 1'b0, 32'hDEADBEEF);
      exp_word = 32'hDEADBEEF;

      // Asynchronous reset mid-cycle with a store pending on the inputs
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11111111, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      #3 rstn = 1'b0;
      #1;
      chk_all("async_rst", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("rst_edge", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      rstn = 1'b1;
      issue_load(32'h10, 5'd8, 2'b10, 1'b0, 32'hDEADBEEF);
      #1;
      chk("rst_release.rfw", {31'd0, oSig_RegfileWrite}, 32'h0);
      step();
      check_load("lw_after_rst", 32'h10, 5'd8);

`ifdef MEMSTAGE_SUBWORD_EN
      store(32'h11, 32'h00000055, 2'b00);
      load("sb_lw", 32'h10, 5'd9, 2'b10, 1'b0, 32'hDE55BEEF);
      load("lb_10", 32'h10, 5'd9, 2'b00, 1'b0, 32'hFFFFFFDE);
      load("lbu_10", 32'h10, 5'd9, 2'b00, 1'b1, 32'h000000DE);
      load("lb_11", 32'h11, 5'd9, 2'b00, 1'b0, 32'h00000055);
      load("lh_12", 32'h12, 5'd9, 2'b01, 1'b0, 32'hFFFFBEEF);
      load("lhu_12", 32'h12, 5'd9, 2'b01, 1'b1, 32'h0000BEEF);
      load("lh_10", 32'h10, 5'd9, 2'b01, 1'b0, 32'hFFFFDE55);
      store(32'h12, 32'h00001234, 2'b01);
      load("sh_lw", 32'h10, 5'd9, 2'b10, 1'b0, 32'hDE551234);
      drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk("lh_11.mis", {31'd0, oMisaligned}, 32'h1);
      chk("lh_11.rfw", {31'd0, oSig_RegfileWrite}, 32'h0);
      exp_word = 32'hDE551234;
`endif

      // Misaligned store leaves RAM untouched; misaligned load blocks write-back
      store(32'h13, 32'hCAFEF00D, 2'b10);
      chk_all("sw_13", 32'h0, 32'h13, 5'd0, 1'b0, 1'b0, 1'b1);
      load("lw_after_sw13", 32'h10, 5'd5, 2'b10, 1'b0, exp_word);
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk("lw_12.mis", {31'd0, oMisaligned}, 32'h1);
      chk("lw_12.rfw", {31'd0, oSig_RegfileWrite}, 32'h0);
      chk("lw_12.wreg", {27'd0, owrite_reg}, 32'd3);

      // Stall for three cycles holds outputs; the store lands on release
      load("lw_prestall", 32'h10, 5'd4, 2'b10, 1'b0, exp_word);
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("stall_hold", exp_word, 32'h10, 5'd4, 1'b1, 1'b1, 1'b0);
      end
      iStall = 1'b0;
      step();
      chk_all("stall_release", 32'h0, 32'h20, 5'd7, 1'b0, 1'b0, 1'b0);
      load("lw_20", 32'h20, 5'd10, 2'b10, 1'b0, 32'hA5A5A5A5);

      // Flush kills a store and bubbles the register; flush wins over stall
      store(32'h24, 32'h12345678, 2'b10);
      load("lw_24", 32'h24, 5'd11, 2'b10, 1'b0, 32'h12345678);
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h24, 32'h77777777, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      chk_all("flush", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      load("lw_24_after_flush", 32'h24, 5'd11, 2'b10, 1'b0, 32'h12345678);
      drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h99999999, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      chk_all("stall_flush", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      load("lw_24_after_sf", 32'h24, 5'd11, 2'b10, 1'b0, 32'h12345678);

      // Read and write together: load sees the pre-write contents
      store(32'h28, 32'hAAAA0000, 2'b10);
      drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h28, 32'hBBBB1111, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk("rw_28.rd", oread_from_ram, 32'hAAAA0000);
      load("lw_28", 32'h28, 5'd12, 2'b10, 1'b0, 32'hBBBB1111);

      // Address wraps modulo the RAM size
      store(32'h1000, 32'h00001234, 2'b10);
      load("wrap_lw_0", 32'h0, 5'd13, 2'b10, 1'b0, 32'h00001234);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
